// File: rtl/hazard_sched.sv
// hazard_sched -- pipeline hazard scheduler for the 5-stage CPU.
//
// Tracks the destination registers of the instructions in EX, MEM and WB.
// Each cycle it decides whether the instruction in ID issues, stalls or is
// squashed. It also produces registered forwarding selects for the EX-stage
// operand muxes.
//
// Build option: define HAZARD_FWD_EN to enable forwarding. A load-use
// dependency then costs one stall cycle. Without the macro the forwarding
// selects are tied to 00, and any dependency on EX, MEM or WB stalls until
// the producer has retired.
//
// Ports:
//   clk, rst               pipeline clock; synchronous active-high reset
//   id_valid               ID stage holds a real instruction
//   id_rs, id_rt           source register numbers of the ID instruction
//   id_use_rs, id_use_rt   ID instruction reads rs / rt
//   id_wreg, id_wdst       ID instruction writes register id_wdst
//   id_memread             ID instruction is a load
//   id_jump                ID instruction is a jump resolved in ID
//   ex_br_taken            branch in EX resolved taken this cycle
//   stall                  hold PC and IF/ID (combinational)
//   bubble                 load a NOP into ID/EX (combinational)
//   flush_if               replace IF/ID with a NOP at the next edge (combinational)
//   fwd_a, fwd_b           EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB (registered)
//   stall_cnt              saturating count of stalled cycles
module hazard_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic [4:0]       id_wdst,
  input  logic             id_memread,
  input  logic             id_jump,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush_if,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic [4:0] dst;
    logic       load;
  } slot_t;

  slot_t ex_q, mem_q, wb_q, ex_d;
  logic  hazard;

  // A slot produces register r only if it is a live writer; $0 never counts.
  function automatic logic match(input slot_t s, input logic [4:0] r);
    return s.valid & s.wreg & (s.dst == r) & (r != 5'd0);
  endfunction

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign hazard = id_valid & ex_q.load &
                  ((id_use_rs & match(ex_q, id_rs)) | (id_use_rt & match(ex_q, id_rt)));
`else
  // Without bypassing, the consumer waits until the producer has left WB.
  assign hazard = id_valid &
                  ((id_use_rs & (match(ex_q, id_rs) | match(mem_q, id_rs) | match(wb_q, id_rs))) |
                   (id_use_rt & (match(ex_q, id_rt) | match(mem_q, id_rt) | match(wb_q, id_rt))));
`endif

  // A taken branch outranks any hazard: the ID instruction is wrong-path.
  // A jump only kills its delay-slot fetch once it actually issues.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    stall    = 1'b0;
    bubble   = 1'b0;
    flush_if = 1'b0;
    if (!rst) begin
      if (ex_br_taken) begin
        flush_if = 1'b1;
        bubble   = 1'b1;
      end else if (hazard) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end else if (id_valid && id_jump) begin
        flush_if = 1'b1;
      end
    end
  end

  // Record of the instruction entering EX at this edge; a bubble is an empty slot.
  always_comb begin
    ex_d.valid = id_valid & ~bubble;
    ex_d.wreg  = id_wreg;
    ex_d.dst   = id_wdst;
    ex_d.load  = id_memread;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so the slot shift reads pre-edge values.
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_d, fwd_b_d;
  logic       unused_wb;

  // WB results reach EX through the register file, so WB is not tracked for bypass.
  assign unused_wb = ^wb_q;

  // EX is checked first because it holds the youngest value of the register.
  function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                         input logic [4:0] r);
    if (match(ex_s, r))  return 2'b01;
    if (match(mem_s, r)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!bubble && id_use_rs) fwd_a_d = fwd_sel(ex_q, mem_q, id_rs);
    if (!bubble && id_use_rt) fwd_b_d = fwd_sel(ex_q, mem_q, id_rt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      fwd_a <= fwd_a_d;
      fwd_b <= fwd_b_d;
    end
  end
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched -- bench for hazard_sched. Two instances share the same
// stimulus: the default 16-bit counter and a 4-bit one for saturation.
// The reference model keeps a queue of issued instructions stamped with their
// issue cycle and derives pipeline position from age.
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wdst = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0;
  logic       id_memread = 1'b0, id_jump = 1'b0, ex_br_taken = 1'b0;

  logic        stall, bubble, flush_if;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic        stall_s, bubble_s, flush_if_s;
  logic [1:0]  fwd_a_s, fwd_b_s;
  logic [3:0]  stall_cnt_s;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  hazard_sched #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wdst(id_wdst),
    .id_memread(id_memread), .id_jump(id_jump), .ex_br_taken(ex_br_taken),
    .stall(stall), .bubble(bubble), .flush_if(flush_if),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt));

  hazard_sched #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wdst(id_wdst),
    .id_memread(id_memread), .id_jump(id_jump), .ex_br_taken(ex_br_taken),
    .stall(stall_s), .bubble(bubble_s), .flush_if(flush_if_s),
    .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_s));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int         at;    // first cycle the instruction sits in EX
    logic       wreg;
    logic [4:0] dst;
    logic       load;
  } rec_t;

  rec_t mq[$];
  int   cyc = 0;
  logic m_stall, m_bubble, m_flush, m_issue;
  logic [1:0] m_fa_d, m_fb_d;
  logic [1:0] mdl_fa = 2'b00, mdl_fb = 2'b00;
  int   mdl_cnt = 0, mdl_cnt4 = 0;

  // Index of the youngest in-flight writer of r, or -1.
  function automatic int youngest(input logic [4:0] r);
    int best;
    best = -1;
    if (r != 5'd0)
      foreach (mq[i]) if (mq[i].wreg && mq[i].dst == r) best = i;
    return best;
  endfunction

  // Age 0 = EX, 1 = MEM, 2 = WB.
  function automatic int age_of(input int idx);
    return (idx < 0) ? 99 : cyc - mq[idx].at;
  endfunction

  function automatic logic [1:0] fwd_from_age(input int age);
    if (age == 0) return 2'b01;
    if (age == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_eval();
    int   ia, ib, aa, ab;
    logic haz;
    ia  = youngest(id_rs);
    ib  = youngest(id_rt);
    aa  = age_of(ia);
    ab  = age_of(ib);
    haz = 1'b0;
`ifdef HAZARD_FWD_EN
    if (id_use_rs && aa == 0 && mq[ia].load) haz = 1'b1;
    if (id_use_rt && ab == 0 && mq[ib].load) haz = 1'b1;
`else
    if (id_use_rs && aa <= 2) haz = 1'b1;
    if (id_use_rt && ab <= 2) haz = 1'b1;
`endif
    haz      = haz && id_valid;
    m_bubble = !rst && (ex_br_taken || haz);
    m_stall  = !rst && haz && !ex_br_taken;
    m_flush  = !rst && (ex_br_taken || (id_valid && id_jump && !haz));
    m_issue  = id_valid && !m_bubble;
    m_fa_d   = 2'b00;
    m_fb_d   = 2'b00;
`ifdef HAZARD_FWD_EN
    if (!m_bubble && id_use_rs) m_fa_d = fwd_from_age(aa);
    if (!m_bubble && id_use_rt) m_fb_d = fwd_from_age(ab);
`endif
  endfunction

  // One clock edge; the model advances alongside the DUT.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mdl_fa = 2'b00; mdl_fb = 2'b00; mdl_cnt = 0; mdl_cnt4 = 0;
    end else begin
      if (m_stall) begin
        if (mdl_cnt < 65535) mdl_cnt++;
        if (mdl_cnt4 < 15) mdl_cnt4++;
      end
      mdl_fa = m_fa_d;
      mdl_fb = m_fb_d;
      if (m_issue) mq.push_back('{at: cyc + 1, wreg: id_wreg, dst: id_wdst, load: id_memread});
    end
    cyc++;
    while (mq.size() > 0 && cyc - mq[0].at > 2) void'(mq.pop_front());
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_wreg = 1'b0; id_wdst = '0; id_memread = 1'b0; id_jump = 1'b0; ex_br_taken = 1'b0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic use_rs,
                           input logic use_rt, input logic wreg, input logic [4:0] wdst,
                           input logic memread, input logic jump);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_use_rs = use_rs; id_use_rt = use_rt;
    id_wreg = wreg; id_wdst = wdst; id_memread = memread; id_jump = jump; ex_br_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
  endtask

  // Holds the current ID instruction and counts cycles until it issues (bounded).
  task automatic count_stalls(output int n);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (stall !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    set_instr(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    ex_br_taken = 1'b1;
    #1;
    checks++;
    if ({stall, bubble, flush_if} !== 3'b000)
      $display("FAIL reset_comb_during: got %b want 000", {stall, bubble, flush_if});
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL reset_fwd: got %b want 0000", {fwd_a, fwd_b});
    if ({fwd_a, fwd_b} !== 4'b0000) errors++;
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
    checks++;
    if (stall_cnt_s !== 4'd0) begin
      errors++; $display("FAIL reset_cnt4: got %0d want 0", stall_cnt_s);
    end
    rst = 1'b0;
    set_idle();
    #1;
    checks++;
    if ({stall, bubble, flush_if} !== 3'b000) begin
      errors++; $display("FAIL reset_comb_after: got %b want 000", {stall, bubble, flush_if});
    end
    tick();
  endtask

  task automatic test_forward();
    int n;
    do_reset();
    set_instr(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);  // addi $1,$0,5
    tick();
    set_instr(5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);  // add $2,$1,$1
    count_stalls(n);
    checks++;
    if (n !== (FWD ? 0 : 3)) begin
      errors++; $display("FAIL fwd_stalls: got %0d want %0d", n, FWD ? 0 : 3);
    end
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== (FWD ? 4'b0101 : 4'b0000)) begin
      errors++; $display("FAIL fwd_sel_ex: got %b want %b", {fwd_a, fwd_b}, FWD ? 4'b0101 : 4'b0000);
    end
    checks++;
    if (stall_cnt !== (FWD ? 16'd0 : 16'd3)) begin
      errors++; $display("FAIL fwd_cnt: got %0d want %0d", stall_cnt, FWD ? 0 : 3);
    end
  endtask

  task automatic test_load_use();
    int n;
    do_reset();
    set_instr(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);  // lw $3,0($0)
    tick();
    set_instr(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);  // sub $4,$3,$5
    #1;
    checks++;
    if ({stall, bubble} !== 2'b11) begin
      errors++; $display("FAIL lu_stall: got %b want 11", {stall, bubble});
    end
    count_stalls(n);
    checks++;
    if (n !== (FWD ? 1 : 3)) begin
      errors++; $display("FAIL lu_stalls: got %0d want %0d", n, FWD ? 1 : 3);
    end
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== (FWD ? 4'b1000 : 4'b0000)) begin
      errors++; $display("FAIL lu_fwd: got %b want %b", {fwd_a, fwd_b}, FWD ? 4'b1000 : 4'b0000);
    end
    checks++;
    if (stall_cnt !== (FWD ? 16'd1 : 16'd3)) begin
      errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, FWD ? 1 : 3);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_instr(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);  // addi $0,$0,7
    tick();
    set_instr(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);  // add $6,$0,$0
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL zero_stall: got %b want 0", stall);
    end
    tick();
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++; $display("FAIL zero_fwd: got %b want 0000", {fwd_a, fwd_b});
    end
  endtask

  task automatic test_branch_vs_hazard();
    do_reset();
    set_instr(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);  // lw $3
    tick();
    set_instr(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);  // sub $4,$3,$5
    ex_br_taken = 1'b1;
    #1;
    checks++;
    if ({stall, bubble, flush_if} !== 3'b011) begin
      errors++; $display("FAIL br_prio: got %b want 011", {stall, bubble, flush_if});
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL br_cnt: got %0d want 0", stall_cnt);
    end
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++; $display("FAIL br_fwd: got %b want 0000", {fwd_a, fwd_b});
    end
  endtask

  task automatic test_jump_stall();
    int n;
    do_reset();
    set_instr(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);  // lw $3
    tick();
    set_instr(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);  // jr $3
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (stall !== 1'b1) break;
      checks++;
      if (flush_if !== 1'b0) begin
        errors++; $display("FAIL jr_flush_held: got %b want 0", flush_if);
      end
      n++;
      tick();
    end
    checks++;
    if (n !== (FWD ? 1 : 3)) begin
      errors++; $display("FAIL jr_stalls: got %0d want %0d", n, FWD ? 1 : 3);
    end
    checks++;
    if (flush_if !== 1'b1) begin
      errors++; $display("FAIL jr_flush_issue: got %b want 1", flush_if);
    end
    tick();
    checks++;
    if (fwd_a !== (FWD ? 2'b10 : 2'b00)) begin
      errors++; $display("FAIL jr_fwd: got %b want %b", fwd_a, FWD ? 2'b10 : 2'b00);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_instr(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);  // lw $3
    tick();
    set_instr(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);  // sub $4,$3,$5
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL rms_pre: got %b want 1", stall);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({stall, bubble, flush_if} !== 3'b000) begin
      errors++; $display("FAIL rms_during: got %b want 000", {stall, bubble, flush_if});
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, bubble, flush_if, fwd_a, fwd_b} !== 7'b0) begin
      errors++; $display("FAIL rms_after: got %b want 0000000", {stall, bubble, flush_if, fwd_a, fwd_b});
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL rms_cnt: got %0d want 0", stall_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    int n, want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_instr(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);  // lw $3
      tick();
      set_instr(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);  // sub $4,$3,$5
      count_stalls(n);
      tick();
      want = (i + 1) * (FWD ? 1 : 3);
      checks++;
      if (stall_cnt !== 16'(want)) begin
        errors++; $display("FAIL sat_cnt16 iter %0d: got %0d want %0d", i, stall_cnt, want);
      end
      checks++;
      if (stall_cnt_s !== 4'((want > 15) ? 15 : want)) begin
        errors++; $display("FAIL sat_cnt4 iter %0d: got %0d want %0d", i, stall_cnt_s,
                           (want > 15) ? 15 : want);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      id_valid    = ($urandom_range(0, 9) != 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_use_rs   = id_valid && ($urandom_range(0, 3) != 0);
      id_use_rt   = id_valid && ($urandom_range(0, 1) == 1);
      id_wreg     = ($urandom_range(0, 3) != 0);
      id_wdst     = 5'($urandom_range(0, 3));
      id_memread  = id_wreg && ($urandom_range(0, 2) == 0);
      id_jump     = ($urandom_range(0, 9) == 0);
      ex_br_taken = ($urandom_range(0, 9) == 0);
      #1;
      model_eval();
      checks++;
      if ({stall, bubble, flush_if} !== {m_stall, m_bubble, m_flush}) begin
        errors++;
        $display("FAIL rnd_comb cyc %0d: got %b want %b", cyc, {stall, bubble, flush_if},
                 {m_stall, m_bubble, m_flush});
      end
      tick();
      checks++;
      if ({fwd_a, fwd_b} !== {mdl_fa, mdl_fb}) begin
        errors++;
        $display("FAIL rnd_fwd cyc %0d: got %b want %b", cyc, {fwd_a, fwd_b}, {mdl_fa, mdl_fb});
      end
      checks++;
      if (stall_cnt !== 16'(mdl_cnt)) begin
        errors++; $display("FAIL rnd_cnt16 cyc %0d: got %0d want %0d", cyc, stall_cnt, mdl_cnt);
      end
      checks++;
      if (stall_cnt_s !== 4'(mdl_cnt4)) begin
        errors++; $display("FAIL rnd_cnt4 cyc %0d: got %0d want %0d", cyc, stall_cnt_s, mdl_cnt4);
      end
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_zero_reg();
    test_branch_vs_hazard();
    test_jump_stall();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline hazard scheduler for the 5-stage CPU: tracks destination registers of instructions in EX, MEM and WB, and decides each cycle whether the ID-stage instruction issues, stalls or is flushed. It consumes the decoded control fields produced by the instruction decoder in ID and the branch outcome from EX. It drives PC/IF-ID hold, ID-EX bubble insertion, IF/ID flush and registered forwarding selects for the EX-stage operand muxes.

## Interface
- `CNT_W`, default 16: width of the saturating stall-cycle counter.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the ID instruction.
- `id_use_rs`, `id_use_rt`  in  1 each  ID instruction reads rs / rt.
- `id_wreg`  in  1  ID instruction writes the register file.
- `id_wdst`  in  5  destination register of the ID instruction (rd or rt, already muxed).
- `id_memread`  in  1  ID instruction is a load.
- `id_jump`  in  1  ID instruction is J/JAL/JR; target known in ID.
- `ex_br_taken`  in  1  branch in EX resolved taken this cycle.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `bubble`  out  1  load a NOP into ID/EX this cycle.
- `flush_if`  out  1  replace IF/ID contents with NOP at next edge.
- `fwd_a`, `fwd_b`  out  2 each  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result; registered.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall`=1.

## Operation
- Tracking state: three slots EX, MEM, WB, each {valid, wreg, dst[4:0], load}. Each edge: WB<=MEM, MEM<=EX, EX<=issued ID instruction, or an invalid slot when `bubble`=1 or `id_valid`=0.
- Match(slot, r): slot.valid & slot.wreg & slot.dst==r & r!=0. Register 0 never causes stall or forwarding.
- Load-use hazard: EX.load & ((id_use_rs & Match(EX,id_rs)) | (id_use_rt & Match(EX,id_rt))) with `id_valid`=1.
- Hazard -> `stall`=1, `bubble`=1. The ID instruction stays put and re-evaluates next cycle.
- `ex_br_taken`=1 -> `flush_if`=1, `bubble`=1, `stall`=0. Branch flush has priority over any hazard (the ID instruction is wrong-path). The EX slot loads invalid.
- `id_jump`=1 with no hazard and no `ex_br_taken` -> `flush_if`=1 (kills the delay-slot fetch). The jump itself issues. A jump that is stalled does not flush until it issues.
- Forward select for the instruction issuing at this edge: per operand, 01 if Match(EX, src), else 10 if Match(MEM, src), else 00. EX has priority because it holds the youngest value. Registered into `fwd_a`/`fwd_b`. The register is loaded with 00 when `bubble`=1 or `id_use_x`=0.
- `stall_cnt` increments on every edge where `stall`=1. It holds at all-ones (saturates) and does not wrap.

## Timing
- `stall`, `bubble`, `flush_if`: combinational, same cycle as inputs. They depend only on tracking registers and current ID/EX inputs; no path from outputs back to inputs.
- `fwd_a`/`fwd_b`: valid during the cycle the instruction occupies EX (1 edge after issue).
- Load-use costs exactly 1 stall cycle with forwarding. The next cycle, the load is in MEM and the consumer issues with fwd=10.
- Taken branch costs 2 squashed instructions (IF/ID and ID/EX). Jump costs 1.
- Reset: all slots invalid. `fwd_a`=`fwd_b`=00, `stall_cnt`=0. `stall`, `bubble` and `flush_if` are 0 during and after reset until inputs demand otherwise.
- Reset asserted mid-stall: next cycle no stall; the in-flight producer is forgotten.
- Simultaneous `ex_br_taken` and load-use hazard: flush wins, and `stall_cnt` does not increment.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding and 1-cycle load-use behaviour as above.
- `HAZARD_FWD_EN` undefined:
  - `fwd_a`/`fwd_b` tied to 00.
  - Hazard = any used source matching the EX, MEM or WB slot, regardless of load. This results in stalls of up to 3 cycles until the producer has left WB.
  - Branch/jump behaviour is unchanged.

## Test plan
- Forwarding from EX/MEM:
  - Stimulus: `addi $1,$0,5` then `add $2,$1,$1`.
  - With `HAZARD_FWD_EN`: no stall, `fwd_a`=`fwd_b`=01 while add is in EX.
  - Without it: 3 stall cycles, `stall_cnt`=3.
- Load-use: `lw $3,0($0)` then `sub $4,$3,$5` -> one cycle `stall`=`bubble`=1, then `fwd_a`=10, `fwd_b`=00, `stall_cnt`=1.
- $0 destination: `addi $0,$0,7` then `add $6,$0,$0` -> no stall, fwd 00/00.
- Branch vs hazard: `ex_br_taken`=1 in the same cycle as a load-use match -> `flush_if`=1, `bubble`=1, `stall`=0, `stall_cnt` unchanged.
- Jump held by stall: a JR reading $3 directly after `lw $3` -> 1 stall cycle with `flush_if`=0, then `flush_if`=1 when the JR issues.
- Reset and saturation:
  - Assert `rst` during a load-use stall -> next cycle all outputs 0.
  - With `CNT_W`=4, hold a hazard 20 cycles -> `stall_cnt` stays 15.
